// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: FIFO-buffered command issue to the APB top, single-entry response; APB_SEQ_TIMEOUT_EN adds ready timeout.
// Latency: pop one edge after accept; write response one edge after apb_ready_i, read response two edges after.
// Backpressure: cmd_ready_o drops when the FIFO is full; no pop while a response is still pending.

module apb_seq_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         pclk,
   input  logic         preset,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge pclk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module apb_cmd_sequencer #(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic [1:0]        add_o,
   output logic [DATA_W-1:0] wdata_o,
   input  logic              apb_ready_i,
   input  logic [DATA_W-1:0] apb_rdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_write_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              busy_o,
   output logic              err_o
);
   typedef enum logic [1:0] {IDLE, ACTIVE, CAPTURE, GAP} state_t;

   state_t            state_q, state_d;
   logic              fifo_full, fifo_empty, push, pop;
   logic [DATA_W:0]   head;
   logic              cur_write_q;
   logic              ld_wr_rsp, ld_rd_rsp, abort, to_hit;

   assign cmd_ready_o = !fifo_full && !preset;
   assign push        = cmd_valid_i && cmd_ready_o;
   assign busy_o      = (state_q != IDLE) || !fifo_empty;

   apb_seq_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
      .pclk     (pclk),
      .preset   (preset),
      .push     (push),
      .push_dat ({cmd_write_i, cmd_wdata_i}),
      .pop      (pop),
      .pop_dat  (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      ld_wr_rsp = 1'b0;
      ld_rd_rsp = 1'b0;
      abort     = 1'b0;
      case (state_q)
         IDLE: begin
            // A pending response blocks issue so every command has somewhere to land.
            if (!fifo_empty && !rsp_valid_o) begin
               pop     = 1'b1;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (apb_ready_i) begin
               if (cur_write_q) begin
                  ld_wr_rsp = 1'b1;
                  state_d   = GAP;
               end else begin
                  state_d   = CAPTURE;
               end
            end else if (to_hit) begin
               abort   = 1'b1;
               state_d = GAP;
            end
         end
         CAPTURE: begin
            ld_rd_rsp = 1'b1;
            state_d   = GAP;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         add_o       <= 2'b00;
         wdata_o     <= '0;
         cur_write_q <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_write_o <= 1'b0;
         rsp_rdata_o <= '0;
      end else begin
         if (pop) begin
            add_o       <= head[DATA_W] ? 2'b11 : 2'b01;
            wdata_o     <= head[DATA_W-1:0];
            cur_write_q <= head[DATA_W];
         end else if (ld_wr_rsp || ld_rd_rsp || abort) begin
            add_o <= 2'b00;
         end
         if (rsp_valid_o && rsp_ready_i) rsp_valid_o <= 1'b0;
         if (ld_wr_rsp || abort) begin
            rsp_valid_o <= 1'b1;
            rsp_write_o <= cur_write_q;
            rsp_rdata_o <= '0;
         end
         if (ld_rd_rsp) begin
            rsp_valid_o <= 1'b1;
            rsp_write_o <= 1'b0;
            rsp_rdata_o <= apb_rdata_i;
         end
      end
   end

`ifdef APB_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;

   // The edge that would take the count to TIMEOUT_CYCLES is the abort edge.
   assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         to_cnt_q  <= '0;
         rsp_err_o <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         if (pop)                                    to_cnt_q <= '0;
         else if (state_q == ACTIVE && !apb_ready_i) to_cnt_q <= to_cnt_q + TO_W'(1);
         if (ld_wr_rsp || ld_rd_rsp) rsp_err_o <= 1'b0;
         if (abort) begin
            rsp_err_o <= 1'b1;
            err_o     <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
   assign to_hit    = 1'b0;
   assign rsp_err_o = 1'b0;
   assign err_o     = 1'b0;
`endif
endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer; the bench itself plays the APB top (ready/rdata).
module tb_apb_cmd_sequencer;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          pclk = 1'b0;
   logic          preset = 1'b1;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_write_i = 1'b0;
   logic [DW-1:0] cmd_wdata_i = '0;
   logic          cmd_ready_o;
   logic [1:0]    add_o;
   logic [DW-1:0] wdata_o;
   logic          apb_ready_i = 1'b0;
   logic [DW-1:0] apb_rdata_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b0;
   logic          rsp_write_o;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_err_o;
   logic          busy_o;
   logic          err_o;

   int total = 0;
   int bad   = 0;

   apb_cmd_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(8)) dut (
      .pclk        (pclk),
      .preset      (preset),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_write_i (cmd_write_i),
      .cmd_wdata_i (cmd_wdata_i),
      .add_o       (add_o),
      .wdata_o     (wdata_o),
      .apb_ready_i (apb_ready_i),
      .apb_rdata_i (apb_rdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_write_o (rsp_write_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .busy_o      (busy_o),
      .err_o       (err_o)
   );

   always #5 pclk = ~pclk;

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic test_reset();
      preset = 1'b1;
      repeat (3) tick();
      total++; if (add_o !== 2'b00) begin bad++; $display("FAIL rst_add got=%b exp=00", add_o); end
      total++; if (wdata_o !== '0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", wdata_o); end
      total++; if ({rsp_valid_o, rsp_write_o, rsp_err_o, err_o, busy_o} !== 5'b0) begin
         bad++; $display("FAIL rst_flags got=%b exp=00000", {rsp_valid_o, rsp_write_o, rsp_err_o, err_o, busy_o}); end
      total++; if (rsp_rdata_o !== '0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata_o); end
      total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready_o); end
      preset = 1'b0;
      #1;
      total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rel_cmd_ready got=%b exp=1", cmd_ready_o); end
   endtask

   task automatic test_write();
      apb_ready_i = 1'b0; rsp_ready_i = 1'b0;
      cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_wdata_i = 32'h1234ABCD;
      tick();
      cmd_valid_i = 1'b0;
      total++; if (add_o !== 2'b00) begin bad++; $display("FAIL wr_accept_add got=%b exp=00", add_o); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy_o); end
      tick();
      total++; if (add_o !== 2'b11 || wdata_o !== 32'h1234ABCD) begin
         bad++; $display("FAIL wr_issue got=%b/%h exp=11/1234abcd", add_o, wdata_o); end
      tick();
      total++; if (add_o !== 2'b11) begin bad++; $display("FAIL wr_hold got=%b exp=11", add_o); end
      apb_ready_i = 1'b1;
      tick();
      apb_ready_i = 1'b0;
      total++; if (add_o !== 2'b00) begin bad++; $display("FAIL wr_done_add got=%b exp=00", add_o); end
      total++; if ({rsp_valid_o, rsp_write_o, rsp_err_o, err_o} !== 4'b1100) begin
         bad++; $display("FAIL wr_rsp got=%b exp=1100", {rsp_valid_o, rsp_write_o, rsp_err_o, err_o}); end
      total++; if (rsp_rdata_o !== '0) begin bad++; $display("FAIL wr_rsp_rdata got=%h exp=0", rsp_rdata_o); end
      tick();
      total++; if (add_o !== 2'b00) begin bad++; $display("FAIL wr_gap got=%b exp=00", add_o); end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      total++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         bad++; $display("FAIL wr_consumed got=%b%b exp=00", rsp_valid_o, busy_o); end
   endtask

   task automatic test_write_read_read();
      logic [1:0]    exp_add [12];
      logic          exp_rv  [12];
      logic          exp_rw  [12];
      logic [DW-1:0] exp_rd  [12];
      exp_add = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
      exp_rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_rw  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_rd  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234ABCD, 32'h0,
                  32'h0, 32'h0, 32'h1234ABCD, 32'h0};
      apb_ready_i = 1'b1; rsp_ready_i = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cmd_valid_i = (k < 3);
         cmd_write_i = (k == 0);
         cmd_wdata_i = (k == 0) ? 32'h1234ABCD : 32'h0;
         apb_rdata_i = (k == 6 || k == 10) ? 32'h1234ABCD : 32'hDEADBEEF;
         tick();
         total++; if (add_o !== exp_add[k] || rsp_valid_o !== exp_rv[k]) begin
            bad++; $display("FAIL wrr_seq[%0d] got=%b/%b exp=%b/%b", k, add_o, rsp_valid_o, exp_add[k], exp_rv[k]); end
         if (exp_rv[k]) begin
            total++; if (rsp_write_o !== exp_rw[k] || rsp_rdata_o !== exp_rd[k]) begin
               bad++; $display("FAIL wrr_rsp[%0d] got=%b/%h exp=%b/%h", k, rsp_write_o, rsp_rdata_o, exp_rw[k], exp_rd[k]); end
         end
         if (k == 1) begin
            total++; if (wdata_o !== 32'h1234ABCD) begin bad++; $display("FAIL wrr_wdata got=%h exp=1234abcd", wdata_o); end
         end
      end
      cmd_valid_i = 1'b0; apb_ready_i = 1'b0; rsp_ready_i = 1'b0;
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL wrr_idle busy got=%b exp=0", busy_o); end
   endtask

   task automatic test_fifo_full();
      int            n = 0;
      int            rsps = 0;
      logic [1:0]    prev = 2'b00;
      logic [DW-1:0] issued [$];
      apb_ready_i = 1'b0; rsp_ready_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_wdata_i = 32'h100 + n;
         if (cmd_ready_o) begin tick(); n++; end
         else tick();
      end
      cmd_valid_i = 1'b0;
      total++; if (n !== DEPTH + 1) begin bad++; $display("FAIL full_accepted got=%0d exp=%0d", n, DEPTH + 1); end
      total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL full_cmd_ready got=%b exp=0", cmd_ready_o); end
      total++; if (add_o !== 2'b11 || wdata_o !== 32'h100) begin
         bad++; $display("FAIL full_active got=%b/%h exp=11/00000100", add_o, wdata_o); end
      apb_ready_i = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (add_o == 2'b11 && prev != 2'b11) issued.push_back(wdata_o);
         if (rsp_valid_o) rsps++;
         prev = add_o;
         tick();
      end
      apb_ready_i = 1'b0; rsp_ready_i = 1'b0;
      total++; if (rsps !== DEPTH + 1) begin bad++; $display("FAIL drain_rsps got=%0d exp=%0d", rsps, DEPTH + 1); end
      for (int i = 0; i < DEPTH + 1; i++) begin
         total++; if (i >= issued.size() || issued[i] !== 32'h100 + i) begin
            bad++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, (i < issued.size()) ? issued[i] : 32'hx, 32'h100 + i); end
      end
      total++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         bad++; $display("FAIL drain_end got=%b%b exp=01", busy_o, cmd_ready_o); end
   endtask

   task automatic test_rsp_stall();
      apb_ready_i = 1'b1; rsp_ready_i = 1'b0; apb_rdata_i = 32'hCAFEF00D;
      cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_wdata_i = 32'h0;
      tick();
      cmd_write_i = 1'b1; cmd_wdata_i = 32'h22;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      tick();
      total++; if ({add_o, rsp_valid_o, rsp_write_o} !== 4'b0010 || rsp_rdata_o !== 32'hCAFEF00D) begin
         bad++; $display("FAIL stall_first got=%b%b%b/%h exp=0010/cafef00d", add_o, rsp_valid_o, rsp_write_o, rsp_rdata_o); end
      for (int c = 0; c < 10; c++) begin
         apb_rdata_i = 32'h0BAD0000 + c;
         tick();
         total++; if ({add_o, rsp_valid_o, rsp_write_o} !== 4'b0010 || rsp_rdata_o !== 32'hCAFEF00D) begin
            bad++; $display("FAIL stall_hold[%0d] got=%b%b%b/%h exp=0010/cafef00d", c, add_o, rsp_valid_o, rsp_write_o, rsp_rdata_o); end
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      total++; if (rsp_valid_o !== 1'b0 || add_o !== 2'b00) begin
         bad++; $display("FAIL stall_release got=%b/%b exp=0/00", rsp_valid_o, add_o); end
      tick();
      total++; if (add_o !== 2'b11 || wdata_o !== 32'h22) begin
         bad++; $display("FAIL stall_next_issue got=%b/%h exp=11/00000022", add_o, wdata_o); end
      tick();
      total++; if (rsp_valid_o !== 1'b1 || rsp_write_o !== 1'b1) begin
         bad++; $display("FAIL stall_next_rsp got=%b%b exp=11", rsp_valid_o, rsp_write_o); end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0; apb_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      apb_ready_i = 1'b0; rsp_ready_i = 1'b0;
      cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_wdata_i = 32'h0;
      tick();
      cmd_write_i = 1'b1; cmd_wdata_i = 32'h33;
      tick();
      cmd_wdata_i = 32'h44;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      total++; if (add_o !== 2'b01) begin bad++; $display("FAIL rmid_pre got=%b exp=01", add_o); end
      preset = 1'b1;
      #1;
      total++; if (add_o !== 2'b00) begin bad++; $display("FAIL rmid_async_add got=%b exp=00", add_o); end
      total++; if ({rsp_valid_o, busy_o, cmd_ready_o} !== 3'b000) begin
         bad++; $display("FAIL rmid_flags got=%b exp=000", {rsp_valid_o, busy_o, cmd_ready_o}); end
      tick();
      preset = 1'b0;
      #1;
      total++; if ({busy_o, cmd_ready_o, add_o} !== 4'b0100) begin
         bad++; $display("FAIL rmid_release got=%b exp=0100", {busy_o, cmd_ready_o, add_o}); end
      apb_ready_i = 1'b1;
      cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_wdata_i = 32'h5A5A5A5A;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      total++; if (add_o !== 2'b11 || wdata_o !== 32'h5A5A5A5A) begin
         bad++; $display("FAIL rmid_new_issue got=%b/%h exp=11/5a5a5a5a", add_o, wdata_o); end
      tick();
      total++; if ({add_o, rsp_valid_o, rsp_write_o} !== 4'b0011) begin
         bad++; $display("FAIL rmid_new_rsp got=%b exp=0011", {add_o, rsp_valid_o, rsp_write_o}); end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0; apb_ready_i = 1'b0;
   endtask

`ifdef APB_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      apb_ready_i = 1'b0; rsp_ready_i = 1'b0;
      cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_wdata_i = 32'h77;
      tick();
      cmd_valid_i = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         total++; if ({add_o, err_o, rsp_valid_o} !== 4'b1100) begin
            bad++; $display("FAIL to_wait[%0d] got=%b exp=1100", k, {add_o, err_o, rsp_valid_o}); end
      end
      tick();
      total++; if ({add_o, rsp_valid_o, rsp_write_o, rsp_err_o, err_o} !== 6'b001111 || rsp_rdata_o !== '0) begin
         bad++; $display("FAIL to_abort got=%b/%h exp=001111/0", {add_o, rsp_valid_o, rsp_write_o, rsp_err_o, err_o}, rsp_rdata_o); end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      total++; if (err_o !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", err_o); end
      apb_rdata_i = 32'h600D;
      cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_wdata_i = 32'h0;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      total++; if (add_o !== 2'b01) begin bad++; $display("FAIL to_next_issue got=%b exp=01", add_o); end
      apb_ready_i = 1'b1;
      tick();
      tick();
      total++; if ({rsp_valid_o, rsp_err_o, err_o} !== 3'b101 || rsp_rdata_o !== 32'h600D) begin
         bad++; $display("FAIL to_next_rsp got=%b/%h exp=101/0000600d", {rsp_valid_o, rsp_err_o, err_o}, rsp_rdata_o); end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0; apb_ready_i = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_write_read_read();
      test_fifo_full();
      test_rsp_stall();
      test_reset_mid();
`ifdef APB_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired before test completion");
      $fatal(1, "watchdog");
   end
endmodule
